// File: rtl/ddr3_app_arbiter.sv
// Round-robin arbiter sharing one MIG DDR3 app interface between two single-command requesters.
// Read data is steered back to the issuing requester through an in-order tag FIFO.
module ddr3_app_arbiter #(
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_WIDTH = 30,
    parameter int pMASK_WIDTH = 4,
    parameter int pTAG_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init_calib_complete,
    input  logic                         r0_req,
    input  logic                         r0_write,
    input  logic [pADDR_WIDTH-1:0]       r0_addr,
    input  logic [pDATA_WIDTH-1:0]       r0_wdata,
    input  logic [pMASK_WIDTH-1:0]       r0_mask,
    output logic                         r0_ack,
    output logic                         r0_rd_valid,
    output logic                         r0_rd_last,
    output logic [pDATA_WIDTH-1:0]       r0_rd_data,
    input  logic                         r1_req,
    input  logic                         r1_write,
    input  logic [pADDR_WIDTH-1:0]       r1_addr,
    input  logic [pDATA_WIDTH-1:0]       r1_wdata,
    input  logic [pMASK_WIDTH-1:0]       r1_mask,
    output logic                         r1_ack,
    output logic                         r1_rd_valid,
    output logic                         r1_rd_last,
    output logic [pDATA_WIDTH-1:0]       r1_rd_data,
    output logic [pADDR_WIDTH-1:0]       app_addr,
    output logic [2:0]                   app_cmd,
    output logic                         app_en,
    output logic [pDATA_WIDTH-1:0]       app_wdf_data,
    output logic [pMASK_WIDTH-1:0]       app_wdf_mask,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    output logic                         app_sr_req,
    output logic                         app_ref_req,
    output logic                         app_zq_req,
    input  logic                         app_rdy,
    input  logic                         app_wdf_rdy,
    input  logic [pDATA_WIDTH-1:0]       app_rd_data,
    input  logic                         app_rd_data_valid,
    input  logic                         app_rd_data_end,
    output logic                         busy,
    output logic [$clog2(pTAG_DEPTH):0]  rd_outstanding,
    output logic                         err_underflow
);
    localparam int PW = $clog2(pTAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                   state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic                     wr_q, wr_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [pDATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [pMASK_WIDTH-1:0]   mask_q, mask_d;
    logic                     cmd_done_q, cmd_done_d;
    logic                     data_done_q, data_done_d;

    logic                     tag_mem_q [pTAG_DEPTH];
    logic [PW-1:0]            wptr_q, rptr_q;
    logic [CW-1:0]            cnt_q;

    logic                     rv0_q, rv1_q, rlast_q, err_q;
    logic [pDATA_WIDTH-1:0]   rdata_q;

    logic fifo_full, fifo_empty, push, pop, head;
    logic elig0, elig1, grant_id, cmd_ok, data_ok, done;

    always_comb begin
        fifo_full  = (cnt_q == CW'(pTAG_DEPTH));
        fifo_empty = (cnt_q == '0);
        elig0      = r0_req & init_calib_complete & (r0_write | ~fifo_full);
        elig1      = r1_req & init_calib_complete & (r1_write | ~fifo_full);
        // Ties go to whoever did not win last time.
        grant_id   = (elig0 & elig1) ? ~last_q : elig1;
        cmd_ok     = cmd_done_q | app_rdy;
        data_ok    = ~wr_q | data_done_q | app_wdf_rdy;
        done       = (state_q == ISSUE) & cmd_ok & data_ok;
        push       = (state_q == ISSUE) & ~cmd_done_q & app_rdy & ~wr_q;
        pop        = app_rd_data_valid & app_rd_data_end & ~fifo_empty;
        head       = tag_mem_q[rptr_q];
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        cmd_done_d  = cmd_done_q;
        data_done_d = data_done_q;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d     = ISSUE;
                    owner_d     = grant_id;
                    last_d      = grant_id;
                    wr_d        = grant_id ? r1_write : r0_write;
                    addr_d      = grant_id ? r1_addr  : r0_addr;
                    wdata_d     = grant_id ? r1_wdata : r0_wdata;
                    mask_d      = grant_id ? r1_mask  : r0_mask;
                    cmd_done_d  = 1'b0;
                    data_done_d = 1'b0;
                end
            end
            ISSUE: begin
                cmd_done_d  = cmd_done_q | app_rdy;
                data_done_d = data_done_q | (wr_q & app_wdf_rdy);
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            rv0_q       <= 1'b0;
            rv1_q       <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            cmd_done_q  <= cmd_done_d;
            data_done_q <= data_done_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push & ~pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop & ~push) cnt_q <= cnt_q - CW'(1);
            // Beats arriving with no outstanding tag are dropped and flagged.
            rv0_q   <= app_rd_data_valid & ~fifo_empty & ~head;
            rv1_q   <= app_rd_data_valid & ~fifo_empty & head;
            rlast_q <= app_rd_data_valid & ~fifo_empty & app_rd_data_end;
            if (app_rd_data_valid & ~fifo_empty) rdata_q <= app_rd_data;
            err_q   <= err_q | (app_rd_data_valid & fifo_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wptr_q] <= owner_q;
    end

    always_comb begin
        app_en         = (state_q == ISSUE) & ~cmd_done_q;
        app_wdf_wren   = (state_q == ISSUE) & wr_q & ~data_done_q;
        app_wdf_end    = app_wdf_wren;
        app_cmd        = wr_q ? 3'b000 : 3'b001;
        app_addr       = addr_q;
        app_wdf_data   = wdata_q;
        app_wdf_mask   = mask_q;
        app_sr_req     = 1'b0;
        app_ref_req    = 1'b0;
        app_zq_req     = 1'b0;
        r0_ack         = done & ~owner_q;
        r1_ack         = done & owner_q;
        r0_rd_valid    = rv0_q;
        r1_rd_valid    = rv1_q;
        r0_rd_last     = rv0_q & rlast_q;
        r1_rd_last     = rv1_q & rlast_q;
        r0_rd_data     = rdata_q;
        r1_rd_data     = rdata_q;
        busy           = (state_q != IDLE) | ~fifo_empty;
        rd_outstanding = cnt_q;
        err_underflow  = err_q;
    end
endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Bench for ddr3_app_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model (per-requester pending request, in-order read queue).
module tb_ddr3_app_arbiter;
    logic        clk = 1'b0;
    logic        reset, init_calib_complete;
    logic        r0_req, r0_write, r1_req, r1_write;
    logic [29:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [3:0]  r0_mask, r1_mask;
    logic        r0_ack, r0_rd_valid, r0_rd_last, r1_ack, r1_rd_valid, r1_rd_last;
    logic [31:0] r0_rd_data, r1_rd_data;
    logic [29:0] app_addr;
    logic [2:0]  app_cmd;
    logic        app_en, app_wdf_wren, app_wdf_end, app_sr_req, app_ref_req, app_zq_req;
    logic [31:0] app_wdf_data;
    logic [3:0]  app_wdf_mask;
    logic        app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end;
    logic [31:0] app_rd_data;
    logic        busy, err_underflow;
    logic [4:0]  rd_outstanding;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr3_app_arbiter dut (
        .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_mask(r0_mask), .r0_ack(r0_ack), .r0_rd_valid(r0_rd_valid),
        .r0_rd_last(r0_rd_last), .r0_rd_data(r0_rd_data),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_mask(r1_mask), .r1_ack(r1_ack), .r1_rd_valid(r1_rd_valid),
        .r1_rd_last(r1_rd_last), .r1_rd_data(r1_rd_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
        .busy(busy), .rd_outstanding(rd_outstanding), .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0; r0_mask = '0;
        r1_req = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0; r1_mask = '0;
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data_valid = 0; app_rd_data_end = 0;
        app_rd_data = '0; init_calib_complete = 1;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        repeat (2) cyc();
        reset = 0;
    endtask

    // Random-phase state
    bit          rq[2], rw[2], exp_v[2], held[2];
    logic [29:0] ra[2];
    logic [31:0] rdat[2];
    logic [3:0]  rm[2];
    int          wait_c[2];
    int          mq[$];
    logic [31:0] exp_d, hs_wd;
    logic        exp_l;
    logic [29:0] hs_addr;
    logic [2:0]  hs_cmd;
    logic [3:0]  hs_wm;
    int          last_ack;
    bit          exp_alt[4];

    initial begin
        int n, stray;
        bit got, ack;
        exp_alt = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1;
        idle_inputs();
        repeat (3) cyc();
        #1;
        chk("rst_ack0", 64'(r0_ack), 0);
        chk("rst_ack1", 64'(r1_ack), 0);
        chk("rst_rv0", 64'(r0_rd_valid), 0);
        chk("rst_rv1", 64'(r1_rd_valid), 0);
        chk("rst_rlast", 64'({r0_rd_last, r1_rd_last}), 0);
        chk("rst_rdata", 64'(r0_rd_data), 0);
        chk("rst_en", 64'(app_en), 0);
        chk("rst_wren", 64'({app_wdf_wren, app_wdf_end}), 0);
        chk("rst_cmd", 64'(app_cmd), 1);
        chk("rst_addr", 64'(app_addr), 0);
        chk("rst_wdata", 64'({app_wdf_data, app_wdf_mask}), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_outst", 64'(rd_outstanding), 0);
        chk("rst_err", 64'(err_underflow), 0);
        chk("rst_tied", 64'({app_sr_req, app_ref_req, app_zq_req}), 0);
        cyc();
        reset = 0;

        // Single write, both ready
        r0_req = 1; r0_write = 1; r0_addr = 30'h10; r0_wdata = 32'hA5A5_A5A5; r0_mask = 4'h0;
        #1;
        chk("wr_T_en", 64'(app_en), 0);
        chk("wr_T_ack", 64'(r0_ack), 0);
        cyc(); #1;
        chk("wr_T1_en", 64'(app_en), 1);
        chk("wr_T1_wren", 64'({app_wdf_wren, app_wdf_end}), 3);
        chk("wr_T1_cmd", 64'(app_cmd), 0);
        chk("wr_T1_addr", 64'(app_addr), 64'h10);
        chk("wr_T1_data", 64'(app_wdf_data), 64'hA5A5_A5A5);
        chk("wr_T1_ack0", 64'(r0_ack), 1);
        chk("wr_T1_ack1", 64'(r1_ack), 0);
        cyc(); r0_req = 0; #1;
        chk("wr_T2_busy", 64'(busy), 0);
        chk("wr_T2_en", 64'(app_en), 0);

        // Write data channel stalled for three cycles
        r1_req = 1; r1_write = 1; r1_addr = 30'h20; r1_wdata = 32'h1234_5678; r1_mask = 4'h3;
        app_wdf_rdy = 0;
        #1;
        cyc(); #1;
        chk("stall_T1_en", 64'(app_en), 1);
        chk("stall_T1_wren", 64'(app_wdf_wren), 1);
        chk("stall_T1_ack", 64'(r1_ack), 0);
        for (int k = 0; k < 2; k++) begin
            cyc(); #1;
            chk("stall_en_drop", 64'(app_en), 0);
            chk("stall_wren_hold", 64'({app_wdf_wren, app_wdf_end}), 3);
            chk("stall_no_ack", 64'(r1_ack), 0);
        end
        cyc(); app_wdf_rdy = 1; #1;
        chk("stall_T4_wren", 64'(app_wdf_wren), 1);
        chk("stall_T4_mask", 64'(app_wdf_mask), 3);
        chk("stall_T4_ack", 64'(r1_ack), 1);
        cyc(); r1_req = 0; #1;
        chk("stall_after_wren", 64'(app_wdf_wren), 0);

        // Alternating reads from reset, then four returned beats
        do_reset();
        r0_req = 1; r0_write = 0; r0_addr = 30'h100;
        r1_req = 1; r1_write = 0; r1_addr = 30'h200;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            #1;
            if (r0_ack | r1_ack) begin
                chk("alt_grant", 64'(r1_ack), 64'(exp_alt[n]));
                chk("alt_addr", 64'(app_addr), exp_alt[n] ? 64'h200 : 64'h100);
                chk("alt_cmd", 64'(app_cmd), 1);
                n++;
            end
            cyc();
        end
        chk("alt_count", 64'(n), 4);
        r0_req = 0; r1_req = 0; #1;
        chk("alt_outst", 64'(rd_outstanding), 4);
        for (int i = 0; i < 5; i++) begin
            app_rd_data_valid = (i < 4);
            app_rd_data_end = (i < 4);
            app_rd_data = 32'hD000_0000 + 32'(i);
            #1;
            if (i > 0) begin
                chk("ret_v0", 64'(r0_rd_valid), 64'(!exp_alt[i-1]));
                chk("ret_v1", 64'(r1_rd_valid), 64'(exp_alt[i-1]));
                chk("ret_data", 64'(exp_alt[i-1] ? r1_rd_data : r0_rd_data), 64'(32'hD000_0000 + 32'(i-1)));
                chk("ret_last", 64'(exp_alt[i-1] ? r1_rd_last : r0_rd_last), 1);
            end
            cyc();
        end
        app_rd_data_valid = 0; app_rd_data_end = 0; #1;
        chk("ret_outst", 64'(rd_outstanding), 0);

        // Tag FIFO full: reads stall, writes still pass
        do_reset();
        r0_req = 1; r0_write = 0; r0_addr = 30'h300;
        n = 0;
        for (int c = 0; c < 80 && n < 16; c++) begin
            #1;
            if (r0_ack) n++;
            cyc();
        end
        chk("full_reads", 64'(n), 16);
        #1;
        chk("full_outst", 64'(rd_outstanding), 16);
        stray = 0;
        repeat (6) begin
            #1;
            if (r0_ack | app_en) stray++;
            cyc();
        end
        chk("full_stall", 64'(stray), 0);
        r1_req = 1; r1_write = 1; r1_addr = 30'h400; r1_wdata = 32'hCAFE_0001; r1_mask = 4'h5;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (r1_ack) got = 1;
            if (r0_ack) stray++;
            cyc();
        end
        chk("full_wr_ack", 64'(got), 1);
        chk("full_rd_blocked", 64'(stray), 0);
        r1_req = 0;
        app_rd_data_valid = 1; app_rd_data_end = 1; app_rd_data = 32'hBEEF_0001;
        #1;
        cyc();
        app_rd_data_valid = 0; app_rd_data_end = 0;
        #1;
        chk("full_ret_v0", 64'(r0_rd_valid), 1);
        chk("full_ret_data", 64'(r0_rd_data), 64'hBEEF_0001);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            #1;
            if (r0_ack) got = 1;
            cyc();
        end
        chk("full_regrant", 64'(got), 1);
        r0_req = 0; #1;
        chk("full_outst2", 64'(rd_outstanding), 16);

        // Read data with nothing outstanding
        do_reset();
        app_rd_data_valid = 1; app_rd_data_end = 1; app_rd_data = 32'h5555_AAAA;
        #1;
        cyc();
        app_rd_data_valid = 0; app_rd_data_end = 0;
        #1;
        chk("uf_v", 64'({r0_rd_valid, r1_rd_valid}), 0);
        chk("uf_err", 64'(err_underflow), 1);
        cyc(); #1;
        chk("uf_sticky", 64'(err_underflow), 1);

        // Reset while a write is stuck in ISSUE
        do_reset();
        r0_req = 1; r0_write = 0; r0_addr = 30'h500;
        #1;
        cyc(); #1;
        chk("rsti_rd_ack", 64'(r0_ack), 1);
        cyc();
        r0_write = 1; r0_addr = 30'h504; r0_wdata = 32'h0F0F_0F0F; app_wdf_rdy = 0;
        #1;
        cyc(); #1;
        chk("rsti_en", 64'({app_en, app_wdf_wren}), 3);
        chk("rsti_outst_pre", 64'(rd_outstanding), 1);
        cyc();
        reset = 1; r0_req = 0;
        #1;
        chk("rsti_wren_pre", 64'(app_wdf_wren), 1);
        cyc();
        reset = 0;
        #1;
        chk("rsti_en_post", 64'({app_en, app_wdf_wren}), 0);
        chk("rsti_busy", 64'(busy), 0);
        chk("rsti_outst", 64'(rd_outstanding), 0);
        app_wdf_rdy = 1;

        // Randomized traffic against the transaction model
        do_reset();
        rq = '{0, 0}; held = '{0, 0}; exp_v = '{0, 0}; wait_c = '{0, 0};
        last_ack = -1; exp_d = '0; exp_l = 0;
        hs_addr = '0; hs_cmd = '0; hs_wd = '0; hs_wm = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < 2; k++) begin
                if (!rq[k] && $urandom_range(0, 2) == 0) begin
                    rq[k] = 1; rw[k] = ($urandom_range(0, 1) == 1);
                    ra[k] = 30'($urandom); rdat[k] = $urandom; rm[k] = 4'($urandom);
                    wait_c[k] = 0;
                end
            end
            r0_req = rq[0]; r0_write = rw[0]; r0_addr = ra[0]; r0_wdata = rdat[0]; r0_mask = rm[0];
            r1_req = rq[1]; r1_write = rw[1]; r1_addr = ra[1]; r1_wdata = rdat[1]; r1_mask = rm[1];
            app_rdy = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 3) != 0);
            app_rd_data_valid = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            app_rd_data_end = ($urandom_range(0, 1) == 1);
            app_rd_data = $urandom;
            #1;
            chk("rnd_v0", 64'(r0_rd_valid), 64'(exp_v[0]));
            chk("rnd_v1", 64'(r1_rd_valid), 64'(exp_v[1]));
            if (exp_v[0] | exp_v[1]) begin
                chk("rnd_rdata", 64'(exp_v[1] ? r1_rd_data : r0_rd_data), 64'(exp_d));
                chk("rnd_rlast", 64'(exp_v[1] ? r1_rd_last : r0_rd_last), 64'(exp_l));
            end
            chk("rnd_outst", 64'(rd_outstanding), 64'(mq.size()));
            for (int k = 0; k < 2; k++)
                if (!rq[k] || (!rw[k] && mq.size() >= 16)) held[k] = 0;
            if (app_en & app_rdy) begin hs_addr = app_addr; hs_cmd = app_cmd; end
            if (app_wdf_wren & app_wdf_rdy) begin hs_wd = app_wdf_data; hs_wm = app_wdf_mask; end
            got = 0;
            for (int k = 0; k < 2; k++) begin
                ack = (k == 1) ? r1_ack : r0_ack;
                if (ack) begin
                    got = 1;
                    chk("rnd_ack_req", 64'(rq[k]), 1);
                    chk("rnd_addr", 64'(hs_addr), 64'(ra[k]));
                    chk("rnd_cmd", 64'(hs_cmd), rw[k] ? 64'd0 : 64'd1);
                    if (rw[k]) begin
                        chk("rnd_wdata", 64'(hs_wd), 64'(rdat[k]));
                        chk("rnd_wmask", 64'(hs_wm), 64'(rm[k]));
                    end
                    if (last_ack == k) chk("rnd_fair", 64'(held[1-k]), 0);
                    last_ack = k;
                    if (!rw[k]) mq.push_back(k);
                    rq[k] = 0;
                end else if (rq[k]) begin
                    wait_c[k]++;
                    if (wait_c[k] > 60) begin
                        chk("rnd_wait", 64'(wait_c[k] <= 60), 1);
                        rq[k] = 0;
                    end
                end
            end
            if (got) held = '{1, 1};
            exp_v = '{0, 0};
            if (app_rd_data_valid) begin
                exp_v[mq[0]] = 1;
                exp_d = app_rd_data;
                exp_l = app_rd_data_end;
                if (app_rd_data_end) void'(mq.pop_front());
            end
            cyc();
        end
        idle_inputs();
        #1;
        chk("rnd_err", 64'(err_underflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr3_app_arbiter.md
# ddr3_app_arbiter

Two-port arbiter that shares a single MIG DDR3 user (app) interface between requester 0 (DDR3 test engine) and requester 1 (host/USB memory-access port). It grants single-command requests round-robin, drives app command and write-data channels with independent handshakes, and steers returned read data to the issuing requester through an in-order tag FIFO. Sits between the requesters and the MIG core.

## Interface
- pDATA_WIDTH, 32, app data width
- pADDR_WIDTH, 30, app address width
- pMASK_WIDTH, 4, write mask width
- pTAG_DEPTH, 16, max outstanding reads (power of 2, >=2)

- clk  in  1  app clock (MIG ui_clk)
- reset  in  1  synchronous, active-high
- init_calib_complete  in  1  no grants while low
- rN_req  in  1  (N=0,1) request valid; held with fields until rN_ack
- rN_write  in  1  1=write, 0=read
- rN_addr  in  pADDR_WIDTH  address
- rN_wdata  in  pDATA_WIDTH  write data
- rN_mask  in  pMASK_WIDTH  write mask
- rN_ack  out  1  one-cycle pulse: request fully accepted by MIG
- rN_rd_valid  out  1  read beat for requester N
- rN_rd_last  out  1  qualifies last beat (app_rd_data_end)
- rN_rd_data  out  pDATA_WIDTH  read data
- app_addr, app_cmd(3), app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end  out  MIG command/write channels
- app_sr_req, app_ref_req, app_zq_req  out  1  tied 0
- app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end  in  MIG handshakes/read return
- busy  out  1  state != IDLE or reads outstanding
- rd_outstanding  out  $clog2(pTAG_DEPTH)+1  tag FIFO occupancy
- err_underflow  out  1  sticky: read data returned with empty tag FIFO

## Operation
- States: IDLE, ISSUE. Registers: owner, last_grant, latched write/addr/wdata/mask, cmd_done, data_done.
- IDLE: eligible N = rN_req & init_calib_complete & (rN_write | tag FIFO not full). Both eligible: grant !last_grant. One eligible: grant it. Grant latches fields, sets owner=last_grant=N, clears cmd_done/data_done, -> ISSUE.
- ISSUE: app_en = !cmd_done; app_cmd = 000 write / 001 read; app_addr = latched addr. For writes app_wdf_wren = app_wdf_end = !data_done, app_wdf_data/mask = latched. Reads: wren/end = 0.
- cmd_ok = cmd_done | app_rdy; data_ok = !write | data_done | app_wdf_rdy. Each channel's done flag sets when its handshake completes; channels complete in either order.
- rN_ack (combinational) = ISSUE & owner==N & cmd_ok & data_ok; same edge -> IDLE.
- Read tag: owner ID pushed into tag FIFO on the cycle app_en & app_rdy for a read. Head popped on app_rd_data_valid & app_rd_data_end.
- Read return: every app_rd_data_valid beat registered to requester at head tag (rd_valid, rd_last=app_rd_data_end, rd_data); other requester's rd_valid = 0. Valid with FIFO empty: no output, err_underflow set (cleared only by reset).
- Push and pop in same cycle: occupancy unchanged. Full: reads not granted; writes still granted.
- init_calib_complete falling in ISSUE: current request completes; only new grants blocked.
- Reset (any time): state IDLE, last_grant=1 (requester 0 wins first tie), FIFO flushed; reset must be coincident with MIG reset.

## Timing
- Reset values: all rN_ack/rd_valid/rd_last 0, rd_data 0, app_en/wdf_wren/wdf_end 0, app_cmd 001, app_addr/wdf_data/mask 0, busy 0, rd_outstanding 0, err_underflow 0.
- req seen in IDLE cycle T -> app_en/wren high in T+1; ack in T+1 if app_rdy & app_wdf_rdy both high then. Min 2 cycles per request.
- Read data latency: rN_rd_valid one cycle after app_rd_data_valid.
- app_en/wren never drop before their handshake; address/data stable while asserted.

## Test plan
- r0 write addr 0x10 data 0xA5A5A5A5, rdy both high -> app_en+wren+end in T+1, app_cmd 000, r0_ack in T+1, busy 0 at T+2.
- r0 and r1 reads held continuously -> grants alternate 0,1,0,1 from reset; MIG returns 4 beats -> rd_valid alternates r0,r1,r0,r1 with matching data.
- Write with app_wdf_rdy low 3 cycles, app_rdy high -> app_en drops after 1 cycle, wren held 4 cycles, ack on 4th.
- 16 reads issued, no return -> rd_outstanding 16, 17th read stalls, r1 write still acked; one return -> read granted.
- app_rd_data_valid after reset with no reads -> no rd_valid, err_underflow 1.
- reset asserted during ISSUE with wdf_rdy low -> next cycle app_en/wren 0, state IDLE, rd_outstanding 0.
